// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    // Default operand width and the matching iteration-counter width.
    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    // alucontrol codes for the divide ops; must stay in step with defines2.vh.
    localparam logic [4:0] DIV_CONTROL  = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL = 5'b11011;

    // Sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // True when the E-stage control code asks for either divide flavour.
    function automatic logic is_div_op(input logic [4:0] ctrl);
        return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// r_in is the partial remainder (always < divisor, so WIDTH bits suffice),
// q_in is the dividend/quotient shift register: its MSB feeds the remainder
// and the new quotient bit enters at the LSB.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_shift;
    logic           qbit;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        r_shift = {r_in, q_in[WIDTH-1]};
        qbit    = (r_shift >= {1'b0, divisor});
        // When the trial succeeds the difference is below the divisor, so it
        // fits in WIDTH bits and the modular subtraction is exact.
        r_out   = qbit ? (r_shift[WIDTH-1:0] - divisor) : r_shift[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage.
// Runs one restoring step per cycle on operand magnitudes, applies the sign
// fixup on the last step, and holds the {remainder, quotient} pair for the
// hilo write path while stalling F/D/E until the result is ready.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         alucontrolE,
    input  logic [WIDTH-1:0]   src_aE,
    input  logic [WIDTH-1:0]   src_bE,
    input  logic               flushE,
    input  logic               pipe_stallE,
    output logic               div_stall,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] hilo_out,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic               valid_q, valid_d;

    logic               start_req;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_step;

    // Request decode and operand magnitude/sign extraction for the start cycle.
    always_comb begin
        start_req = is_div_op(alucontrolE) && !flushE;
        is_signed = (alucontrolE == DIV_CONTROL);
        a_neg     = is_signed && src_aE[WIDTH-1];
        b_neg     = is_signed && src_bE[WIDTH-1];
        // Two's-complement negate; 0x80..0 maps to itself, which is the
        // correct unsigned magnitude.
        a_mag     = a_neg ? (~src_aE + WIDTH'(1)) : src_aE;
        b_mag     = b_neg ? (~src_bE + WIDTH'(1)) : src_bE;
    end

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .r_in    (rem_q),
        .q_in    (quo_q),
        .divisor (dvs_q),
        .r_out   (step_rem),
        .q_out   (step_quo)
    );

    // Sign fixup on the final step's output: quotient follows sign(a)^sign(b),
    // remainder follows sign(a). Divide-by-zero goes through the same path.
    always_comb begin
        quo_fix   = neg_quo_q ? (~step_quo + WIDTH'(1)) : step_quo;
        rem_fix   = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hilo_d    = hilo_q;
        valid_d   = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                // A held request (pipe_stallE high) still starts: E keeps the instruction.
                if (start_req) begin
                    state_d   = DIV_BUSY;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end
            end
            DIV_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = DIV_DONE;
                    hilo_d  = {rem_fix, quo_fix};
                    valid_d = 1'b1;
                end
            end
            DIV_DONE: begin
                // The requesting instruction leaves E when the pipe moves, so
                // DONE never restarts directly.
                if (pipe_stallE) begin
                    valid_d = 1'b1;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (flushE && (state_q != DIV_IDLE)) begin
            state_d = DIV_IDLE;
            valid_d = 1'b0;
            hilo_d  = hilo_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hilo_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hilo_q    <= hilo_d;
            valid_q   <= valid_d;
        end
    end

    // Pipeline stall covers the start cycle and every BUSY cycle; forced low during reset.
    always_comb begin
        div_stall = !rst && (((state_q == DIV_IDLE) && start_req) || (state_q == DIV_BUSY));
    end

    assign result_valid = valid_q;
    assign hilo_out     = hilo_q;
    assign busy         = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq.
module tb_div_seq;
    import div_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [4:0] NOP = 5'd0;

    logic           clk = 1'b0;
    logic           rst;
    logic [4:0]     alucontrolE;
    logic [W-1:0]   src_aE;
    logic [W-1:0]   src_bE;
    logic           flushE;
    logic           pipe_stallE;
    logic           div_stall;
    logic           result_valid;
    logic [2*W-1:0] hilo_out;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held = '0;
    logic           rv_prev = 1'b0;

    div_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alucontrolE  (alucontrolE),
        .src_aE       (src_aE),
        .src_bE       (src_bE),
        .flushE       (flushE),
        .pipe_stallE  (pipe_stallE),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .hilo_out     (hilo_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic with the divider's zero and overflow rules.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            // All-ones quotient, then negated when a is negative (b counts as positive).
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Monitor: pop on the first DONE cycle, then require a stable result while held.
    always @(negedge clk) begin
        #2;
        if (result_valid) begin
            if (!rv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected no result at %0t", hilo_out, $time);
                end else begin
                    held = exp_q.pop_front();
                    check64("hilo_out", hilo_out, held);
                end
            end else begin
                check64("hilo_stable", hilo_out, held);
            end
        end
        rv_prev = result_valid;
    end

    // abort_mode: 0 = run to completion, 1 = flush in BUSY cycle abort_cyc, 2 = reset in that cycle.
    task automatic run_div(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv, input int hold, input int abort_mode, input int abort_cyc);
        @(negedge clk);
        alucontrolE = ctrl;
        src_aE      = a;
        src_bE      = b;
        flushE      = 1'b0;
        pipe_stallE = 1'($urandom_range(0, 1));
        #1;
        check1("stall_c0", div_stall, 1'b1);
        check1("busy_c0", busy, 1'b0);
        if (abort_mode == 0) exp_q.push_back(expv);
        for (int c = 1; c <= int'(W); c++) begin
            @(negedge clk);
            src_aE      = $urandom;
            src_bE      = $urandom;
            pipe_stallE = 1'($urandom_range(0, 1));
            if (abort_mode == 1 && c == abort_cyc + 1) begin
                flushE      = 1'b0;
                alucontrolE = NOP;
                pipe_stallE = 1'b0;
                #1;
                check1("flush_stall", div_stall, 1'b0);
                check1("flush_busy", busy, 1'b0);
                check1("flush_valid", result_valid, 1'b0);
                return;
            end
            if (abort_mode == 1 && c == abort_cyc) flushE = 1'b1;
            if (abort_mode == 2 && c == abort_cyc) begin
                #1;
                rst = 1'b1;
                #1;
                check1("rst_busy", busy, 1'b0);
                check1("rst_valid", result_valid, 1'b0);
                check1("rst_stall", div_stall, 1'b0);
                check64("rst_hilo", hilo_out, 64'd0);
                @(negedge clk);
                rst         = 1'b0;
                alucontrolE = NOP;
                pipe_stallE = 1'b0;
                return;
            end
            #1;
            check1("stall_busy", div_stall, 1'b1);
            check1("busy", busy, 1'b1);
            check1("valid_low", result_valid, 1'b0);
        end
        // Cycle WIDTH+1: DONE.
        @(negedge clk);
        pipe_stallE = (hold > 0);
        if (hold == 0) alucontrolE = NOP;
        #1;
        check1("done_stall", div_stall, 1'b0);
        check1("done_valid", result_valid, 1'b1);
        check1("done_busy", busy, 1'b1);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            pipe_stallE = (h < hold);
            if (h == hold) alucontrolE = NOP;
            #1;
            check1("hold_valid", result_valid, 1'b1);
            check1("hold_stall", div_stall, 1'b0);
        end
        @(negedge clk);
        #1;
        check1("exit_busy", busy, 1'b0);
        check1("exit_valid", result_valid, 1'b0);
        check1("exit_stall", div_stall, 1'b0);
    endtask

    initial begin
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;

        rst         = 1'b1;
        alucontrolE = DIVU_CONTROL;
        src_aE      = 32'd9;
        src_bE      = 32'd3;
        flushE      = 1'b0;
        pipe_stallE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check1("reset_busy", busy, 1'b0);
        check1("reset_valid", result_valid, 1'b0);
        check1("reset_stall", div_stall, 1'b0);
        check64("reset_hilo", hilo_out, 64'd0);
        alucontrolE = NOP;
        rst         = 1'b0;

        run_div(DIVU_CONTROL, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0, 0);
        run_div(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0, 0);
        run_div(DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1, 0, 0);
        run_div(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 0, 0);
        run_div(DIVU_CONTROL, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 0, 0, 0);
        run_div(DIVU_CONTROL, 32'd1000, 32'd3, {32'd1, 32'd333}, 3, 0, 0);

        // Flush in BUSY cycle 10: no result may appear afterwards.
        run_div(DIVU_CONTROL, 32'd50, 32'd5, 64'd0, 0, 1, 10);
        repeat (5) begin
            @(negedge clk);
            #1;
            check1("post_flush_valid", result_valid, 1'b0);
        end

        // Reset mid-BUSY, then a fresh divide must be correct.
        run_div(DIV_CONTROL, 32'd123, 32'd4, 64'd0, 0, 2, 15);
        run_div(DIVU_CONTROL, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            ctrl = ($urandom_range(0, 1) == 0) ? DIV_CONTROL : DIVU_CONTROL;
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = {{16{b[15]}}, b[15:0]};
            run_div(ctrl, a, b, ref_div(ctrl == DIV_CONTROL, a, b), int'($urandom_range(0, 2)), 0, 0);
        end

        repeat (3) @(negedge clk);
        check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
